// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the USB device transaction FSM: PID constants,
// the transaction state enum, the handshake retry limit and a helper that
// maps a data toggle bit onto its DATA0/DATA1 PID.
// Optional feature macro used by the design: USB_DEV_TOGGLE_EN.
// ---------------------------------------------------------------------------
package usb_pkg;

   localparam logic [7:0] PID_OUT   = 8'b1000_0111;
   localparam logic [7:0] PID_IN    = 8'b1001_0110;
   localparam logic [7:0] PID_DATA0 = 8'b1100_0011;
   localparam logic [7:0] PID_DATA1 = 8'b1101_0010;
   localparam logic [7:0] PID_ACK   = 8'b0100_1011;
   localparam logic [7:0] PID_NAK   = 8'b0101_1010;

   // Number of unacknowledged IN deliveries after which the packet is dropped.
   localparam logic [3:0] FAIL_LIMIT = 4'd8;

   typedef enum logic [2:0] {
      IDLE,
      RECV_DATA,
      SEND_HAND,
      SEND_DATA,
      RECV_HAND
   } state_t;

   function automatic logic [7:0] data_pid_for(input logic toggle);
      return toggle ? PID_DATA1 : PID_DATA0;
   endfunction

endpackage

// File: rtl/usb_dev_fsm_if.sv
// ---------------------------------------------------------------------------
// usb_dev_fsm_if
// Groups every signal exchanged between the transaction FSM and its
// surroundings (token receiver, data/handshake receivers, senders and the
// OUT/IN buffers).
//   master : the surroundings -- drives tokens, receiver results, sender done
//            pulses and buffer status; observes the FSM's starts and status.
//   slave  : the FSM itself.
// Signals:
//   my_addr[6:0], tok_valid, tok_pid[7:0], tok_addr[6:0]
//   r_data_done, r_data_ok, r_data_pid[7:0], r_data_timeout
//   r_hand_done, r_hand_pid[7:0], r_hand_timeout
//   done_send_data, done_send_hand, rx_full, tx_ready
//   r_data_start, r_hand_start, start_send_data, start_send_hand,
//   send_pid[7:0], rx_commit, tx_consume, xfer_ok, xfer_fail
// ---------------------------------------------------------------------------
interface usb_dev_fsm_if;

   logic [6:0] my_addr;
   logic       tok_valid;
   logic [7:0] tok_pid;
   logic [6:0] tok_addr;

   logic       r_data_done;
   logic       r_data_ok;
   logic [7:0] r_data_pid;
   logic       r_data_timeout;

   logic       r_hand_done;
   logic [7:0] r_hand_pid;
   logic       r_hand_timeout;

   logic       done_send_data;
   logic       done_send_hand;
   logic       rx_full;
   logic       tx_ready;

   logic       r_data_start;
   logic       r_hand_start;
   logic       start_send_data;
   logic       start_send_hand;
   logic [7:0] send_pid;
   logic       rx_commit;
   logic       tx_consume;
   logic       xfer_ok;
   logic       xfer_fail;

   modport master (
      output my_addr, tok_valid, tok_pid, tok_addr,
      output r_data_done, r_data_ok, r_data_pid, r_data_timeout,
      output r_hand_done, r_hand_pid, r_hand_timeout,
      output done_send_data, done_send_hand, rx_full, tx_ready,
      input  r_data_start, r_hand_start, start_send_data, start_send_hand,
      input  send_pid, rx_commit, tx_consume, xfer_ok, xfer_fail
   );

   modport slave (
      input  my_addr, tok_valid, tok_pid, tok_addr,
      input  r_data_done, r_data_ok, r_data_pid, r_data_timeout,
      input  r_hand_done, r_hand_pid, r_hand_timeout,
      input  done_send_data, done_send_hand, rx_full, tx_ready,
      output r_data_start, r_hand_start, start_send_data, start_send_hand,
      output send_pid, rx_commit, tx_consume, xfer_ok, xfer_fail
   );

endinterface

// File: rtl/usb_dev_fsm_toggle.sv
// ---------------------------------------------------------------------------
// usb_toggle
// Holds the OUT-direction (rx) and IN-direction (tx) data toggle bits.
// Only exists when USB_DEV_TOGGLE_EN is defined.
// Ports:
//   clk, rst_l           clock, synchronous active-high reset
//   rx_flip, tx_flip     single-cycle requests to invert the matching toggle
//   rx_toggle, tx_toggle current toggle values (0 = DATA0 expected/sent)
// ---------------------------------------------------------------------------
`ifdef USB_DEV_TOGGLE_EN
module usb_toggle (
   input  logic clk,
   input  logic rst_l,
   input  logic rx_flip,
   input  logic tx_flip,
   output logic rx_toggle,
   output logic tx_toggle
);

   // Each toggle advances only when a transfer in its direction has really
   // completed; a reset brings both sides back to DATA0.
   always_ff @(posedge clk) begin
      if (rst_l) begin
         rx_toggle <= 1'b0;
         tx_toggle <= 1'b0;
      end else begin
         if (rx_flip) begin
            rx_toggle <= ~rx_toggle;
         end
         if (tx_flip) begin
            tx_toggle <= ~tx_toggle;
         end
      end
   end

endmodule
`endif

// File: rtl/usb_dev_fsm.sv
// ---------------------------------------------------------------------------
// usb_dev_fsm
// Device-side USB transaction sequencer. Reacts to OUT/IN tokens addressed
// to my_addr, starts the data/handshake receivers and senders, picks the
// handshake or data PID to send, and reports completion status.
// Ports:
//   clk    system clock
//   rst_l  synchronous active-high reset
//   bus    usb_dev_fsm_if.slave (tokens, receiver/sender results, buffer
//          status in; start pulses, send_pid and status pulses out)
// Optional feature: define USB_DEV_TOGGLE_EN to enable DATA0/DATA1 toggle
// tracking and duplicate OUT detection. Without it IN data always uses
// DATA0 and every good, unblocked OUT is committed.
// All outputs are registered and appear the cycle after their trigger.
// ---------------------------------------------------------------------------
module usb_dev_fsm
   import usb_pkg::*;
(
   input  logic         clk,
   input  logic         rst_l,
   usb_dev_fsm_if.slave bus
);

   state_t     state;
   state_t     state_nxt;

   logic [3:0] fail_cnt;
   logic [3:0] fail_cnt_nxt;
   logic       ack_commit;
   logic       ack_commit_nxt;

   logic       r_data_start_r,    r_data_start_nxt;
   logic       r_hand_start_r,    r_hand_start_nxt;
   logic       start_send_data_r, start_send_data_nxt;
   logic       start_send_hand_r, start_send_hand_nxt;
   logic [7:0] send_pid_r,        send_pid_nxt;
   logic       rx_commit_r,       rx_commit_nxt;
   logic       tx_consume_r,      tx_consume_nxt;
   logic       xfer_ok_r,         xfer_ok_nxt;
   logic       xfer_fail_r,       xfer_fail_nxt;

   logic       tok_hit;
   logic       out_hit;
   logic       in_hit;
   logic       data_good;
   logic       data_fail;
   logic       hand_ack;
   logic       hand_fail;
   logic       fail_at_limit;
   logic       data_match;
   logic [7:0] in_data_pid;

   // Input decode. A done pulse always wins over a coincident timeout, so
   // the timeout only counts when no done pulse is present.
   assign tok_hit       = bus.tok_valid && (bus.tok_addr == bus.my_addr);
   assign out_hit       = tok_hit && (bus.tok_pid == PID_OUT);
   assign in_hit        = tok_hit && (bus.tok_pid == PID_IN);
   assign data_good     = bus.r_data_done && bus.r_data_ok;
   assign data_fail     = (bus.r_data_done && !bus.r_data_ok) ||
                          (!bus.r_data_done && bus.r_data_timeout);
   assign hand_ack      = bus.r_hand_done && (bus.r_hand_pid == PID_ACK);
   assign hand_fail     = (bus.r_hand_done && (bus.r_hand_pid != PID_ACK)) ||
                          (!bus.r_hand_done && bus.r_hand_timeout);
   assign fail_at_limit = (fail_cnt == (FAIL_LIMIT - 4'd1));

`ifdef USB_DEV_TOGGLE_EN
   logic rx_toggle;
   logic tx_toggle;
   logic rx_flip;
   logic tx_flip;

   // The rx toggle advances exactly when an OUT packet is committed; the tx
   // toggle advances only when the host acknowledges our IN data.
   assign rx_flip = rx_commit_nxt;
   assign tx_flip = (state == RECV_HAND) && hand_ack;

   usb_toggle u_toggle (
      .clk       (clk),
      .rst_l     (rst_l),
      .rx_flip   (rx_flip),
      .tx_flip   (tx_flip),
      .rx_toggle (rx_toggle),
      .tx_toggle (tx_toggle)
   );

   // A data PID that does not match the expected toggle is a retransmission
   // of a packet we already committed: it is ACKed but not committed again.
   assign data_match  = (bus.r_data_pid == data_pid_for(rx_toggle));
   assign in_data_pid = data_pid_for(tx_toggle);
`else
   assign data_match  = 1'b1;
   assign in_data_pid = PID_DATA0;
`endif

   // State register plus all registered outputs and bookkeeping. Reset
   // drops any transaction in flight without reporting status.
   always_ff @(posedge clk) begin
      if (rst_l) begin
         state             <= IDLE;
         fail_cnt          <= 4'd0;
         ack_commit        <= 1'b0;
         r_data_start_r    <= 1'b0;
         r_hand_start_r    <= 1'b0;
         start_send_data_r <= 1'b0;
         start_send_hand_r <= 1'b0;
         send_pid_r        <= 8'h00;
         rx_commit_r       <= 1'b0;
         tx_consume_r      <= 1'b0;
         xfer_ok_r         <= 1'b0;
         xfer_fail_r       <= 1'b0;
      end else begin
         state             <= state_nxt;
         fail_cnt          <= fail_cnt_nxt;
         ack_commit        <= ack_commit_nxt;
         r_data_start_r    <= r_data_start_nxt;
         r_hand_start_r    <= r_hand_start_nxt;
         start_send_data_r <= start_send_data_nxt;
         start_send_hand_r <= start_send_hand_nxt;
         send_pid_r        <= send_pid_nxt;
         rx_commit_r       <= rx_commit_nxt;
         tx_consume_r      <= tx_consume_nxt;
         xfer_ok_r         <= xfer_ok_nxt;
         xfer_fail_r       <= xfer_fail_nxt;
      end
   end

   // Next-state logic. Tokens are only looked at in IDLE; every other state
   // waits for the result of the sub-FSM it started.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (out_hit) begin
               state_nxt = RECV_DATA;
            end else if (in_hit) begin
               state_nxt = bus.tx_ready ? SEND_DATA : SEND_HAND;
            end
         end
         RECV_DATA: begin
            if (data_good) begin
               state_nxt = SEND_HAND;
            end else if (data_fail) begin
               state_nxt = IDLE;
            end
         end
         SEND_HAND: begin
            if (bus.done_send_hand) begin
               state_nxt = IDLE;
            end
         end
         SEND_DATA: begin
            if (bus.done_send_data) begin
               state_nxt = RECV_HAND;
            end
         end
         RECV_HAND: begin
            if (hand_ack || hand_fail) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic, computing the values registered on the next edge.
   // send_pid holds its last value between loads so the active sender sees
   // a stable PID until its done pulse. ack_commit remembers whether the
   // handshake in flight is an ACK for a committed packet, which is the only
   // case that earns xfer_ok when the handshake finishes.
   always_comb begin
      fail_cnt_nxt        = fail_cnt;
      ack_commit_nxt      = ack_commit;
      r_data_start_nxt    = 1'b0;
      r_hand_start_nxt    = 1'b0;
      start_send_data_nxt = 1'b0;
      start_send_hand_nxt = 1'b0;
      send_pid_nxt        = send_pid_r;
      rx_commit_nxt       = 1'b0;
      tx_consume_nxt      = 1'b0;
      xfer_ok_nxt         = 1'b0;
      xfer_fail_nxt       = 1'b0;
      case (state)
         IDLE: begin
            if (out_hit) begin
               r_data_start_nxt = 1'b1;
            end else if (in_hit) begin
               if (bus.tx_ready) begin
                  start_send_data_nxt = 1'b1;
                  send_pid_nxt        = in_data_pid;
               end else begin
                  start_send_hand_nxt = 1'b1;
                  send_pid_nxt        = PID_NAK;
                  ack_commit_nxt      = 1'b0;
               end
            end
         end
         RECV_DATA: begin
            if (data_good) begin
               start_send_hand_nxt = 1'b1;
               if (bus.rx_full) begin
                  send_pid_nxt   = PID_NAK;
                  ack_commit_nxt = 1'b0;
               end else begin
                  send_pid_nxt   = PID_ACK;
                  rx_commit_nxt  = data_match;
                  ack_commit_nxt = data_match;
               end
            end else if (data_fail) begin
               xfer_fail_nxt = 1'b1;
            end
         end
         SEND_HAND: begin
            if (bus.done_send_hand) begin
               xfer_ok_nxt    = ack_commit;
               ack_commit_nxt = 1'b0;
            end
         end
         SEND_DATA: begin
            if (bus.done_send_data) begin
               r_hand_start_nxt = 1'b1;
            end
         end
         RECV_HAND: begin
            if (hand_ack) begin
               tx_consume_nxt = 1'b1;
               xfer_ok_nxt    = 1'b1;
               fail_cnt_nxt   = 4'd0;
            end else if (hand_fail) begin
               if (fail_at_limit) begin
                  tx_consume_nxt = 1'b1;
                  xfer_fail_nxt  = 1'b1;
                  fail_cnt_nxt   = 4'd0;
               end else begin
                  fail_cnt_nxt = fail_cnt + 4'd1;
               end
            end
         end
         default: begin
            fail_cnt_nxt = fail_cnt;
         end
      endcase
   end

   assign bus.r_data_start    = r_data_start_r;
   assign bus.r_hand_start    = r_hand_start_r;
   assign bus.start_send_data = start_send_data_r;
   assign bus.start_send_hand = start_send_hand_r;
   assign bus.send_pid        = send_pid_r;
   assign bus.rx_commit       = rx_commit_r;
   assign bus.tx_consume      = tx_consume_r;
   assign bus.xfer_ok         = xfer_ok_r;
   assign bus.xfer_fail       = xfer_fail_r;

endmodule

// File: tb/tb_usb_dev_fsm.sv
// ---------------------------------------------------------------------------
// tb_usb_dev_fsm
// Self-checking bench for usb_dev_fsm. The bench plays the role of the
// token receiver, data/handshake receivers and senders. Each transaction
// pushes the output events it should cause into a queue; a negedge monitor
// pops and compares one entry for every pulse the DUT raises.
// Expectations follow USB_DEV_TOGGLE_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_usb_dev_fsm;
   import usb_pkg::*;

   localparam logic [7:0] EV_RDS     = 8'd1;
   localparam logic [7:0] EV_RHS     = 8'd2;
   localparam logic [7:0] EV_SSD     = 8'd3;
   localparam logic [7:0] EV_SSH     = 8'd4;
   localparam logic [7:0] EV_COMMIT  = 8'd5;
   localparam logic [7:0] EV_CONSUME = 8'd6;
   localparam logic [7:0] EV_OK      = 8'd7;
   localparam logic [7:0] EV_FAIL    = 8'd8;

   localparam logic [6:0] MY_ADDR    = 7'h05;

   logic clk = 1'b0;
   logic rst_l;

   usb_dev_fsm_if bus ();

   usb_dev_fsm dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] expQ[$];
   int          compareCount  = 0;
   int          mismatchCount = 0;
   bit          modelRxTog    = 1'b0;
   bit          modelTxTog    = 1'b0;
   int          modelFailCnt  = 0;
   logic [7:0]  lastSendPid   = 8'h00;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] pulseVec();
      return {bus.r_data_start, bus.r_hand_start, bus.start_send_data,
              bus.start_send_hand, bus.rx_commit, bus.tx_consume,
              bus.xfer_ok, bus.xfer_fail};
   endfunction

   // Model: does a good, unblocked OUT with this data PID get committed?
   function automatic bit modelCommit(input logic [7:0] dpid);
      bit hit;
`ifdef USB_DEV_TOGGLE_EN
      hit = (dpid == (modelRxTog ? PID_DATA1 : PID_DATA0));
      if (hit) modelRxTog = !modelRxTog;
`else
      hit = 1'b1;
`endif
      return hit;
   endfunction

   function automatic logic [7:0] modelInPid();
`ifdef USB_DEV_TOGGLE_EN
      return modelTxTog ? PID_DATA1 : PID_DATA0;
`else
      return PID_DATA0;
`endif
   endfunction

   task automatic scoreEvent(input logic [7:0] kind, input logic [7:0] pid);
      logic [15:0] exp;
      if (expQ.size() == 0) exp = 16'h0000;
      else exp = expQ.pop_front();
      checkOutput($sformatf("event_kind%0d", kind), {16'h0, kind, pid}, {16'h0, exp});
   endtask

   // Monitor: every pulse the DUT raises must match the next expected event.
   always @(negedge clk) begin
      if (bus.r_data_start    === 1'b1) scoreEvent(EV_RDS, 8'h00);
      if (bus.r_hand_start    === 1'b1) scoreEvent(EV_RHS, 8'h00);
      if (bus.start_send_data === 1'b1) scoreEvent(EV_SSD, bus.send_pid);
      if (bus.start_send_hand === 1'b1) scoreEvent(EV_SSH, bus.send_pid);
      if (bus.rx_commit       === 1'b1) scoreEvent(EV_COMMIT, 8'h00);
      if (bus.tx_consume      === 1'b1) scoreEvent(EV_CONSUME, 8'h00);
      if (bus.xfer_ok         === 1'b1) scoreEvent(EV_OK, 8'h00);
      if (bus.xfer_fail       === 1'b1) scoreEvent(EV_FAIL, 8'h00);
   end

   // All drive tasks start and end on a falling edge.
   task automatic applyStimulus(input logic [7:0] pid, input logic [6:0] addr);
      bus.tok_pid   = pid;
      bus.tok_addr  = addr;
      bus.tok_valid = 1'b1;
      @(negedge clk);
      bus.tok_valid = 1'b0;
   endtask

   task automatic pulseData(input bit done, input bit ok, input logic [7:0] dpid,
                            input bit timeout);
      bus.r_data_done    = done;
      bus.r_data_ok      = ok;
      bus.r_data_pid     = dpid;
      bus.r_data_timeout = timeout;
      @(negedge clk);
      bus.r_data_done    = 1'b0;
      bus.r_data_timeout = 1'b0;
   endtask

   task automatic pulseSendDone(input bit isData, input logic [7:0] expPid, input string tag);
      checkOutput({tag, "_pid_hold"}, {24'h0, bus.send_pid}, {24'h0, expPid});
      if (isData) bus.done_send_data = 1'b1;
      else bus.done_send_hand = 1'b1;
      @(negedge clk);
      bus.done_send_data = 1'b0;
      bus.done_send_hand = 1'b0;
   endtask

   task automatic pulseHand(input bit done, input logic [7:0] hpid, input bit timeout);
      bus.r_hand_done    = done;
      bus.r_hand_pid     = hpid;
      bus.r_hand_timeout = timeout;
      @(negedge clk);
      bus.r_hand_done    = 1'b0;
      bus.r_hand_timeout = 1'b0;
   endtask

   // which: 0 r_data_start, 1 r_hand_start, 2 start_send_data, 3 start_send_hand
   task automatic waitPulse(input int which, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         case (which)
            0:       seen = (bus.r_data_start === 1'b1);
            1:       seen = (bus.r_hand_start === 1'b1);
            2:       seen = (bus.start_send_data === 1'b1);
            default: seen = (bus.start_send_hand === 1'b1);
         endcase
         if (!seen) @(negedge clk);
      end
      if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic drain(input string tag);
      repeat (2) @(negedge clk);
      checkOutput({tag, "_drain"}, expQ.size(), 32'd0);
   endtask

   // OUT transaction; a stray IN token while receiving data must be ignored.
   task automatic doOut(input logic [7:0] dpid, input bit done, input bit ok,
                        input bit timeout, input bit full, input string tag);
      bit commit;
      bus.rx_full = full;
      expQ.push_back({EV_RDS, 8'h00});
      applyStimulus(PID_OUT, MY_ADDR);
      waitPulse(0, {tag, "_rds"});
      applyStimulus(PID_IN, MY_ADDR);
      if ((done && !ok) || (!done && timeout)) begin
         expQ.push_back({EV_FAIL, 8'h00});
         pulseData(done, ok, dpid, timeout);
      end else if (full) begin
         expQ.push_back({EV_SSH, PID_NAK});
         lastSendPid = PID_NAK;
         pulseData(done, ok, dpid, timeout);
         waitPulse(3, {tag, "_ssh"});
         pulseSendDone(1'b0, PID_NAK, tag);
      end else begin
         commit = modelCommit(dpid);
         expQ.push_back({EV_SSH, PID_ACK});
         if (commit) expQ.push_back({EV_COMMIT, 8'h00});
         if (commit) expQ.push_back({EV_OK, 8'h00});
         lastSendPid = PID_ACK;
         pulseData(done, ok, dpid, timeout);
         waitPulse(3, {tag, "_ssh"});
         pulseSendDone(1'b0, PID_ACK, tag);
      end
      drain(tag);
   endtask

   // IN transaction. hand: 0 ACK, 1 timeout, 2 NAK PID, 3 ACK with timeout.
   task automatic doIn(input bit ready, input int hand, input string tag);
      logic [7:0] dpid;
      bus.tx_ready = ready;
      if (!ready) begin
         expQ.push_back({EV_SSH, PID_NAK});
         lastSendPid = PID_NAK;
         applyStimulus(PID_IN, MY_ADDR);
         waitPulse(3, {tag, "_ssh"});
         pulseSendDone(1'b0, PID_NAK, tag);
      end else begin
         dpid = modelInPid();
         lastSendPid = dpid;
         expQ.push_back({EV_SSD, dpid});
         expQ.push_back({EV_RHS, 8'h00});
         if (hand == 0 || hand == 3) begin
            expQ.push_back({EV_CONSUME, 8'h00});
            expQ.push_back({EV_OK, 8'h00});
            modelTxTog   = !modelTxTog;
            modelFailCnt = 0;
         end else begin
            modelFailCnt++;
            if (modelFailCnt == 8) begin
               expQ.push_back({EV_CONSUME, 8'h00});
               expQ.push_back({EV_FAIL, 8'h00});
               modelFailCnt = 0;
            end
         end
         applyStimulus(PID_IN, MY_ADDR);
         waitPulse(2, {tag, "_ssd"});
         pulseSendDone(1'b1, dpid, tag);
         waitPulse(1, {tag, "_rhs"});
         case (hand)
            0:       pulseHand(1'b1, PID_ACK, 1'b0);
            1:       pulseHand(1'b0, 8'h00, 1'b1);
            2:       pulseHand(1'b1, PID_NAK, 1'b0);
            default: pulseHand(1'b1, PID_ACK, 1'b1);
         endcase
      end
      drain(tag);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      bus.my_addr        = MY_ADDR;
      bus.tok_valid      = 1'b0;
      bus.tok_pid        = 8'h00;
      bus.tok_addr       = 7'h00;
      bus.r_data_done    = 1'b0;
      bus.r_data_ok      = 1'b0;
      bus.r_data_pid     = 8'h00;
      bus.r_data_timeout = 1'b0;
      bus.r_hand_done    = 1'b0;
      bus.r_hand_pid     = 8'h00;
      bus.r_hand_timeout = 1'b0;
      bus.done_send_data = 1'b0;
      bus.done_send_hand = 1'b0;
      bus.rx_full        = 1'b0;
      bus.tx_ready       = 1'b0;
      rst_l              = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_pulses", {24'h0, pulseVec()}, 32'h0);
      checkOutput("reset_send_pid", {24'h0, bus.send_pid}, 32'h0);
      rst_l = 1'b0;
      @(negedge clk);

      // OUT path: first DATA0, duplicate DATA0, DATA1, blocked, bad, lost.
      doOut(PID_DATA0, 1'b1, 1'b1, 1'b0, 1'b0, "out_d0");
      doOut(PID_DATA0, 1'b1, 1'b1, 1'b0, 1'b0, "out_d0_dup");
      doOut(PID_DATA1, 1'b1, 1'b1, 1'b0, 1'b0, "out_d1");
      doOut(PID_DATA0, 1'b1, 1'b1, 1'b0, 1'b1, "out_full");
      doOut(PID_DATA0, 1'b1, 1'b0, 1'b0, 1'b0, "out_crc");
      doOut(PID_DATA0, 1'b0, 1'b0, 1'b1, 1'b0, "out_tmo");
      doOut(PID_DATA0, 1'b1, 1'b1, 1'b1, 1'b0, "out_done_tmo");

      // Tokens that must be ignored: wrong address, non-token PID.
      applyStimulus(PID_OUT, 7'h06);
      applyStimulus(PID_IN, 7'h06);
      applyStimulus(PID_ACK, MY_ADDR);
      drain("addr_miss");
      checkOutput("addr_miss_send_pid", {24'h0, bus.send_pid}, {24'h0, lastSendPid});

      // IN path.
      doIn(1'b0, 0, "in_nak");
      doIn(1'b1, 0, "in_ack");
      doIn(1'b1, 2, "in_hand_nak");
      doIn(1'b1, 3, "in_ack_tmo");
      for (int i = 0; i < 8; i++) begin
         doIn(1'b1, 1, $sformatf("in_retry%0d", i));
      end
      doIn(1'b1, 0, "in_after_drop");

      // Reset while the DUT waits for the data sender.
      bus.tx_ready = 1'b1;
      lastSendPid  = modelInPid();
      expQ.push_back({EV_SSD, lastSendPid});
      applyStimulus(PID_IN, MY_ADDR);
      waitPulse(2, "rst_mid_ssd");
      rst_l = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid_pulses", {24'h0, pulseVec()}, 32'h0);
      checkOutput("rst_mid_send_pid", {24'h0, bus.send_pid}, 32'h0);
      rst_l        = 1'b0;
      modelRxTog   = 1'b0;
      modelTxTog   = 1'b0;
      modelFailCnt = 0;
      lastSendPid  = 8'h00;
      drain("rst_mid");
      doIn(1'b1, 0, "in_post_rst");
      doOut(PID_DATA0, 1'b1, 1'b1, 1'b0, 1'b0, "out_post_rst");

      repeat (3) @(negedge clk);
      checkOutput("final_queue", expQ.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
